// File: rtl/paddle_motion.sv
// paddle_motion: per-player air-hockey paddle mover.
// Decodes the PS/2 make/break stream into held-direction bits for one player
// (WASD on side 0, extended arrows on side 1). On each frame tick it moves the
// paddle per axis, allowing diagonals, and clamps it to that player's half of
// the rink.
// Build option: define PADDLE_ACCEL_EN to ramp velocity by one every
// ACCEL_TICKS ticks. Without it, a pressed axis moves at the full speed cap
// and ACCEL_TICKS is unused.
//
// Decoder states:
//   state      | meaning
//   ST_WAIT    | idle, next byte is a prefix or a plain make code
//   ST_EXT     | E0 seen, next byte is an extended make code or F0
//   ST_BRK     | F0 seen, next byte is a plain break code
//   ST_EXT_BRK | E0 F0 seen, next byte is an extended break code
module paddle_motion #(
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int R_W         = 6,
  parameter int MAX_SPEED   = 8,
  parameter int ACCEL_TICKS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic [7:0]     ps2_code,
  input  logic           ps2_valid,
  input  logic           run,
  input  logic           side,
  input  logic [1:0]     speed_mode,
  input  logic [R_W-1:0] paddle_r,
  input  logic [X_W-1:0] max_x,
  input  logic [Y_W-1:0] max_y,
  output logic [X_W-1:0] x_pos,
  output logic [Y_W-1:0] y_pos,
  output logic           moving
);

  localparam int XS = X_W + 2;
  localparam int YS = Y_W + 2;
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam int K_UP = 0;
  localparam int K_DN = 1;
  localparam int K_LT = 2;
  localparam int K_RT = 3;

  typedef enum logic [1:0] {ST_WAIT, ST_EXT, ST_BRK, ST_EXT_BRK} dec_state_e;

  dec_state_e state_q, state_d;
  logic       key_make, key_break, key_ext;
  logic [3:0] key_hit;
  logic [3:0] held_q, held_d;

  // Axis index 0 = x, 1 = y.
  logic [1:0]      dir_neg, dir_pos;
  logic [5:0]      cap;
  logic [1:0][5:0] vel_q, vel_d;

  logic [X_W-1:0] x_q, x_d, home_x;
  logic [Y_W-1:0] y_q, y_d, home_y;
  logic [XS-1:0]  home_x3;
  logic signed [XS-1:0] half_x, r_xs, x_lo, x_hi, x_step, x_new;
  logic signed [YS-1:0] my_s, r_ys, y_lo, y_hi, y_step, y_new;

  // Map a decoded byte to the held-bit it controls for the active side.
  // Codes with the wrong extension for that side map to nothing.
  function automatic logic [3:0] key_lookup(input logic ext, input logic [7:0] code,
                                            input logic sd);
    logic [3:0] hit;
    hit = '0;
    if (!sd && !ext) begin
      case (code)
        8'h1D:   hit[K_UP] = 1'b1;
        8'h1B:   hit[K_DN] = 1'b1;
        8'h1C:   hit[K_LT] = 1'b1;
        8'h23:   hit[K_RT] = 1'b1;
        default: hit = '0;
      endcase
    end else if (sd && ext) begin
      case (code)
        8'h75:   hit[K_UP] = 1'b1;
        8'h72:   hit[K_DN] = 1'b1;
        8'h6B:   hit[K_LT] = 1'b1;
        8'h74:   hit[K_RT] = 1'b1;
        default: hit = '0;
      endcase
    end
    return hit;
  endfunction

  // Decoder next state and the make/break event for the current byte.
  always_comb begin
    state_d   = state_q;
    key_make  = 1'b0;
    key_break = 1'b0;
    key_ext   = 1'b0;
    if (ps2_valid) begin
      case (state_q)
        ST_WAIT: begin
          if (ps2_code == CODE_EXT)      state_d = ST_EXT;
          else if (ps2_code == CODE_BRK) state_d = ST_BRK;
          else                           key_make = 1'b1;
        end
        ST_EXT: begin
          if (ps2_code == CODE_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            key_make = 1'b1;
            key_ext  = 1'b1;
            state_d  = ST_WAIT;
          end
        end
        ST_BRK: begin
          key_break = 1'b1;
          state_d   = ST_WAIT;
        end
        ST_EXT_BRK: begin
          key_break = 1'b1;
          key_ext   = 1'b1;
          state_d   = ST_WAIT;
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  // Held-key bits; the decoder keeps running while stopped but holds nothing.
  always_comb begin
    key_hit = key_lookup(key_ext, ps2_code, side);
    held_d  = held_q;
    if (key_make)       held_d = held_q | key_hit;
    else if (key_break) held_d = held_q & ~key_hit;
    if (!run)           held_d = '0;
  end

  // Opposing keys cancel, so each axis is -1, 0 or +1 independently.
  assign dir_neg = {held_q[K_UP] & ~held_q[K_DN], held_q[K_LT] & ~held_q[K_RT]};
  assign dir_pos = {held_q[K_DN] & ~held_q[K_UP], held_q[K_RT] & ~held_q[K_LT]};

  // Speed cap selected by speed_mode.
  always_comb begin
    case (speed_mode)
      2'd0:    cap = 6'd1;
      2'd1:    cap = 6'd2;
      2'd2:    cap = 6'd4;
      default: cap = 6'(MAX_SPEED);
    endcase
  end

`ifdef PADDLE_ACCEL_EN
  localparam int CNT_W = $clog2(ACCEL_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_TICKS - 1);

  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  // Direction seen at the previous tick, {neg,pos}; detects start and reversal.
  logic [1:0][1:0]       dir_q, dir_d;

  // Per-axis ramp: restart at 1 on a new or reversed direction, then add one
  // every ACCEL_TICKS ticks up to the cap. A lowered cap clamps at once.
  always_comb begin
    vel_d = vel_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    for (int a = 0; a < 2; a++) begin
      if (!run) begin
        vel_d[a] = '0;
        cnt_d[a] = '0;
        dir_d[a] = '0;
      end else if (tick) begin
        dir_d[a] = {dir_neg[a], dir_pos[a]};
        if (!(dir_neg[a] | dir_pos[a])) begin
          vel_d[a] = '0;
          cnt_d[a] = '0;
        end else if ({dir_neg[a], dir_pos[a]} != dir_q[a]) begin
          vel_d[a] = 6'd1;
          cnt_d[a] = '0;
        end else if (cnt_q[a] == CNT_LAST) begin
          cnt_d[a] = '0;
          vel_d[a] = (vel_q[a] >= cap) ? cap : vel_q[a] + 6'd1;
        end else begin
          cnt_d[a] = cnt_q[a] + 1'b1;
          vel_d[a] = (vel_q[a] > cap) ? cap : vel_q[a];
        end
      end else if (vel_q[a] > cap) begin
        vel_d[a] = cap;
      end
    end
  end

  // Ramp counters and last-tick direction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dir_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end
`else
  // Without ramping a pressed axis moves at the cap from the first tick.
  always_comb begin
    vel_d = vel_q;
    for (int a = 0; a < 2; a++) begin
      if (!run)                 vel_d[a] = '0;
      else if (tick)            vel_d[a] = (dir_neg[a] | dir_pos[a]) ? cap : 6'd0;
      else if (vel_q[a] > cap)  vel_d[a] = cap;
    end
  end
`endif

  // Home point, bounds for this side, and the saturated next position.
  // Arithmetic is two bits wider than the coordinate so a step past zero
  // or past the rink edge stays signed and clamps instead of wrapping.
  always_comb begin
    home_x3 = {2'b00, max_x} + {1'b0, max_x, 1'b0};
    home_x  = side ? home_x3[X_W+1:2] : (max_x >> 2);
    home_y  = max_y >> 1;

    half_x = $signed({3'b000, max_x[X_W-1:1]});
    r_xs   = $signed({{(XS-R_W){1'b0}}, paddle_r});
    r_ys   = $signed({{(YS-R_W){1'b0}}, paddle_r});
    my_s   = $signed({2'b00, max_y});
    if (side) begin
      x_lo = half_x + r_xs;
      x_hi = $signed({2'b00, max_x}) - r_xs;
    end else begin
      x_lo = r_xs;
      x_hi = half_x - r_xs;
    end
    y_lo = r_ys;
    y_hi = my_s - r_ys;

    x_step = '0;
    if (dir_pos[0])      x_step = $signed({{(XS-6){1'b0}}, vel_d[0]});
    else if (dir_neg[0]) x_step = -$signed({{(XS-6){1'b0}}, vel_d[0]});
    y_step = '0;
    if (dir_pos[1])      y_step = $signed({{(YS-6){1'b0}}, vel_d[1]});
    else if (dir_neg[1]) y_step = -$signed({{(YS-6){1'b0}}, vel_d[1]});

    x_new = $signed({2'b00, x_q}) + x_step;
    y_new = $signed({2'b00, y_q}) + y_step;

    x_d = x_q;
    y_d = y_q;
    if (!run) begin
      x_d = home_x;
      y_d = home_y;
    end else if (tick) begin
      if (x_new < x_lo)      x_d = x_lo[X_W-1:0];
      else if (x_new > x_hi) x_d = x_hi[X_W-1:0];
      else                   x_d = x_new[X_W-1:0];
      if (y_new < y_lo)      y_d = y_lo[Y_W-1:0];
      else if (y_new > y_hi) y_d = y_hi[Y_W-1:0];
      else                   y_d = y_new[Y_W-1:0];
    end
  end

  // Decoder, held keys, velocity and position registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      held_q  <= '0;
      vel_q   <= '0;
      x_q     <= home_x;
      y_q     <= home_y;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      vel_q   <= vel_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign x_pos  = x_q;
  assign y_pos  = y_q;
  assign moving = (vel_q != '0);

endmodule

// File: tb/tb_paddle_motion.sv
module tb_paddle_motion;
  localparam int X_W         = 10;
  localparam int Y_W         = 9;
  localparam int R_W         = 6;
  localparam int MAX_SPEED   = 8;
  localparam int ACCEL_TICKS = 4;

  logic           clk = 1'b0;
  logic           rst_n, tick, ps2_valid, run, side;
  logic [7:0]     ps2_code;
  logic [1:0]     speed_mode;
  logic [R_W-1:0] paddle_r;
  logic [X_W-1:0] max_x;
  logic [Y_W-1:0] max_y;
  logic [X_W-1:0] x_pos;
  logic [Y_W-1:0] y_pos;
  logic           moving;

  paddle_motion #(.X_W(X_W), .Y_W(Y_W), .R_W(R_W), .MAX_SPEED(MAX_SPEED),
                  .ACCEL_TICKS(ACCEL_TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .ps2_code(ps2_code), .ps2_valid(ps2_valid),
    .run(run), .side(side), .speed_mode(speed_mode), .paddle_r(paddle_r),
    .max_x(max_x), .max_y(max_y), .x_pos(x_pos), .y_pos(y_pos), .moving(moving));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: position, per-axis speed/counter/direction, held keys
  // indexed up/down/left/right, and pending prefix flags of the byte stream.
  int  m_x, m_y;
  int  m_v[2], m_cnt[2], m_dir[2];
  bit  m_held[4];
  bit  m_ext, m_brk;
  int  key_codes[2][4] = '{'{'h1D, 'h1B, 'h1C, 'h23}, '{'h75, 'h72, 'h6B, 'h74}};
  logic [7:0] pend[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int cap_of(input logic [1:0] sm);
    case (sm)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return MAX_SPEED;
    endcase
  endfunction

  function automatic int key_index(input bit ext, input logic [7:0] code, input bit sd);
    int s;
    s = sd ? 1 : 0;
    if (ext != sd) return -1;
    for (int i = 0; i < 4; i++) if (int'(code) == key_codes[s][i]) return i;
    return -1;
  endfunction

  task automatic m_home();
    m_x = side ? (3 * int'(max_x)) / 4 : int'(max_x) / 4;
    m_y = int'(max_y) / 2;
  endtask

  // Advance the reference by one clock using the inputs currently applied.
  task automatic model_update();
    int cap, d, lo, hi, idx, r;
    cap = cap_of(speed_mode);
    r   = int'(paddle_r);
    if (!rst_n) begin
      m_home();
      for (int i = 0; i < 4; i++) m_held[i] = 0;
      for (int a = 0; a < 2; a++) begin m_v[a] = 0; m_cnt[a] = 0; m_dir[a] = 0; end
      m_ext = 0;
      m_brk = 0;
      return;
    end
    if (!run) begin
      m_home();
      for (int a = 0; a < 2; a++) begin m_v[a] = 0; m_cnt[a] = 0; m_dir[a] = 0; end
    end else if (tick) begin
      for (int a = 0; a < 2; a++) begin
        d = (a == 0) ? (int'(m_held[3]) - int'(m_held[2])) : (int'(m_held[1]) - int'(m_held[0]));
`ifdef PADDLE_ACCEL_EN
        if (d == 0) begin
          m_v[a] = 0; m_cnt[a] = 0;
        end else if (d != m_dir[a]) begin
          m_v[a] = 1; m_cnt[a] = 0;
        end else begin
          m_cnt[a]++;
          if (m_cnt[a] == ACCEL_TICKS) begin m_v[a]++; m_cnt[a] = 0; end
        end
        if (m_v[a] > cap) m_v[a] = cap;
`else
        m_v[a] = (d != 0) ? cap : 0;
`endif
        m_dir[a] = d;
        if (a == 0) m_x += d * m_v[a];
        else        m_y += d * m_v[a];
      end
      lo = r;
      hi = int'(max_y) - r;
      if (m_y < lo) m_y = lo; else if (m_y > hi) m_y = hi;
      if (side) begin lo = int'(max_x) / 2 + r; hi = int'(max_x) - r; end
      else begin lo = r; hi = int'(max_x) / 2 - r; end
      if (m_x < lo) m_x = lo; else if (m_x > hi) m_x = hi;
    end else begin
      for (int a = 0; a < 2; a++) if (m_v[a] > cap) m_v[a] = cap;
    end
    if (ps2_valid) begin
      if (m_brk) begin
        idx = key_index(m_ext, ps2_code, side);
        if (idx >= 0) m_held[idx] = 0;
        m_ext = 0;
        m_brk = 0;
      end else if (ps2_code == 8'hF0) begin
        m_brk = 1;
      end else if (!m_ext && ps2_code == 8'hE0) begin
        m_ext = 1;
      end else begin
        idx = key_index(m_ext, ps2_code, side);
        if (idx >= 0) m_held[idx] = 1;
        m_ext = 0;
      end
    end
    if (!run) for (int i = 0; i < 4; i++) m_held[i] = 0;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check("x_pos", x_pos, m_x);
    check("y_pos", y_pos, m_y);
    check("moving", moving, (m_v[0] != 0 || m_v[1] != 0));
    tick      = 1'b0;
    ps2_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    ps2_code  = b;
    ps2_valid = 1'b1;
    step();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    step();
  endtask

  task automatic go_home(input logic sd);
    run  = 1'b0;
    side = sd;
    step();
    run = 1'b1;
    step();
  endtask

  task automatic gen_event();
    int sd, k;
    bit brk;
    if ($urandom_range(0, 9) >= 8) begin
      pend.push_back(8'($urandom_range(0, 255)));
      return;
    end
    sd = side ? 1 : 0;
    if ($urandom_range(0, 4) == 0) sd = 1 - sd;
    k   = $urandom_range(0, 3);
    brk = ($urandom_range(0, 9) < 4);
    if (sd == 1) pend.push_back(8'hE0);
    if (brk)     pend.push_back(8'hF0);
    pend.push_back(8'(key_codes[sd][k]));
  endtask

`ifdef PADDLE_ACCEL_EN
  int w_trace[12] = '{239, 238, 237, 236, 234, 232, 230, 228, 225, 222, 219, 216};
  localparam int REV_Y   = 185;
  localparam int RST_W_Y = 239;
`else
  int w_trace[12] = '{232, 224, 216, 208, 200, 192, 184, 176, 168, 160, 152, 144};
  localparam int REV_Y   = 164;
  localparam int RST_W_Y = 236;
`endif

  initial begin
    rst_n = 1'b0; tick = 1'b0; ps2_valid = 1'b0; ps2_code = 8'h00;
    run = 1'b0; side = 1'b0; speed_mode = 2'd3;
    paddle_r = 6'd16; max_x = 10'd640; max_y = 9'd480;

    step();
    check("reset_x_side0", x_pos, 160);
    check("reset_y", y_pos, 240);
    check("reset_moving", moving, 0);
    side = 1'b1;
    step();
    check("reset_x_side1", x_pos, 480);

    // Hold W at the top speed mode.
    side = 1'b0;
    step();
    rst_n = 1'b1;
    run   = 1'b1;
    step();
    send(8'h1D);
    for (int k = 0; k < 12; k++) begin
      tick = 1'b1;
      step();
      check("w_trace", y_pos, w_trace[k]);
      step();
    end
    send(8'hF0); send(8'h1D);
    do_tick(); do_tick();
    check("w_release_y", y_pos, w_trace[11]);
    check("w_release_moving", moving, 0);

    // Diagonal on the arrow side; a non-extended 75 is not the up arrow.
    speed_mode = 2'd0;
    go_home(1'b1);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h74);
    for (int k = 0; k < 4; k++) begin
      tick = 1'b1;
      step();
      check("diag_x", x_pos, 480 + k + 1);
      check("diag_y", y_pos, 240 - k - 1);
      step();
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'h75);
    do_tick(); do_tick();
    check("nonext_ignored_x", x_pos, 484);
    check("nonext_ignored_y", y_pos, 236);

    // Saturation against the centre line from both sides.
    speed_mode = 2'd2;
    go_home(1'b0);
    send(8'h23);
    for (int k = 0; k < 100; k++) do_tick();
    check("sat_side0_x", x_pos, 304);
    send(8'hF0); send(8'h23);
    go_home(1'b1);
    send(8'hE0); send(8'h6B);
    for (int k = 0; k < 100; k++) do_tick();
    check("sat_side1_x", x_pos, 336);
    send(8'hE0); send(8'hF0); send(8'h6B);

    // Opposing keys cancel.
    go_home(1'b0);
    send(8'h1D); send(8'h1B);
    do_tick(); do_tick(); do_tick();
    check("ws_y", y_pos, 240);
    check("ws_moving", moving, 0);

    // Up for 20 ticks, then reverse.
    send(8'hF0); send(8'h1B);
    for (int k = 0; k < 20; k++) do_tick();
    send(8'hF0); send(8'h1D); send(8'h1B);
    tick = 1'b1;
    step();
    check("reverse_y", y_pos, REV_Y);
    do_tick(); do_tick();

    // Stop mid-move: home on the very next cycle, no tick needed.
    run = 1'b0;
    step();
    check("stop_x", x_pos, 160);
    check("stop_y", y_pos, 240);
    check("stop_moving", moving, 0);
    run = 1'b1;
    step();

    // Reset while the decoder waits for an extended break code.
    send(8'hE0); send(8'hF0);
    rst_n = 1'b0;
    step();
    check("rst_ebrk_y", y_pos, 240);
    rst_n = 1'b1;
    send(8'h1D);
    tick = 1'b1;
    step();
    check("rst_ebrk_decoder_wait", y_pos, RST_W_Y);
    step();

    // Randomised traffic against the reference.
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      if (run) begin if ($urandom_range(0, 249) == 0) run = 1'b0; end
      else if ($urandom_range(0, 29) == 0) run = 1'b1;
      if ($urandom_range(0, 299) == 0) side = ~side;
      if ($urandom_range(0, 49) == 0) speed_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        case ($urandom_range(0, 2))
          0: begin max_x = 10'd640; max_y = 9'd480; paddle_r = 6'd16; end
          1: begin max_x = 10'd320; max_y = 9'd240; paddle_r = 6'd8;  end
          default: begin max_x = 10'd800; max_y = 9'd500; paddle_r = 6'd20; end
        endcase
      end
      tick = ($urandom_range(0, 2) == 0);
      if (pend.size() == 0 && $urandom_range(0, 3) == 0) gen_event();
      if (pend.size() != 0 && $urandom_range(0, 1) == 0) begin
        ps2_code  = pend.pop_front();
        ps2_valid = 1'b1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
